// File: rtl/picorv32_mem_cache_if.sv
// picorv32 native memory bus, used for both the core-facing and memory-facing sides of the cache.
// Handshake: the master raises valid with instr/addr/wdata/wstrb and holds them stable until the slave
// pulses ready for exactly one cycle; rdata is meaningful only while ready=1, and wstrb=0 means read.
interface picorv32_mem_cache_if;
  logic        valid;
  logic        instr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ready;
  logic [31:0] rdata;

  modport master (
    output valid, instr, addr, wdata, wstrb,
    input  ready, rdata
  );

  modport slave (
    input  valid, instr, addr, wdata, wstrb,
    output ready, rdata
  );
endinterface

// File: rtl/picorv32_mem_cache.sv
// Direct-mapped, write-through, one-word-per-line read cache between the picorv32 core and slow memory.
// Addresses at or above UNCACHED_BASE always go straight to memory (MMIO such as the console).
module picorv32_mem_cache #(
  parameter int          LINES         = 256,
  parameter logic [31:0] UNCACHED_BASE = 32'h1000_0000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  picorv32_mem_cache_if.slave         cpu,
  picorv32_mem_cache_if.master        mem,
  output logic [31:0]                 hit_count,
  output logic [31:0]                 miss_count,
  output logic [1:0]                  dbg_state
);

  localparam int IDX   = $clog2(LINES);
  localparam int TAG_W = 30 - IDX;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEM_REQ = 2'd1,
    RESP    = 2'd2
  } state_t;

  state_t state, state_next;

  logic [LINES-1:0] line_valid;
  logic [TAG_W-1:0] line_tag  [LINES];
  logic [31:0]      line_data [LINES];

  logic [IDX-1:0]   lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             cacheable;
  logic             is_read;
  logic             lk_hit;

  logic             accept;
  logic             rd_hit;
  logic             rd_miss;
  logic             wr_hit;
  logic             clear_lines;
  logic             mem_done;

  logic             flush_pend;
  logic             fill_pend;
  logic [IDX-1:0]   fill_idx;
  logic [TAG_W-1:0] fill_tag;

  assign dbg_state = state;

  // A pending flush already invalidates every line, so lookups must not hit while it waits.
  assign lk_idx    = cpu.addr[2 +: IDX];
  assign lk_tag    = cpu.addr[31 -: TAG_W];
  assign cacheable = cpu.addr < UNCACHED_BASE;
  assign is_read   = cpu.wstrb == 4'b0000;
  assign lk_hit    = line_valid[lk_idx] && (line_tag[lk_idx] == lk_tag) && !flush_pend;
  assign mem_done  = (state == MEM_REQ) && mem.ready;

  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    rd_hit      = 1'b0;
    rd_miss     = 1'b0;
    wr_hit      = 1'b0;
    clear_lines = 1'b0;
    case (state)
      IDLE: begin
        accept      = cpu.valid && !cpu.ready;
        clear_lines = flush_pend || (flush && !accept);
        if (accept) begin
          rd_hit     = cacheable && is_read && lk_hit;
          rd_miss    = cacheable && is_read && !lk_hit;
          wr_hit     = cacheable && !is_read && lk_hit;
          state_next = (cacheable && is_read && lk_hit) ? RESP : MEM_REQ;
        end
      end
      MEM_REQ: begin
        if (mem.ready) state_next = RESP;
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cpu.ready  <= 1'b0;
      cpu.rdata  <= 32'h0;
      mem.valid  <= 1'b0;
      mem.instr  <= 1'b0;
      mem.addr   <= 32'h0;
      mem.wdata  <= 32'h0;
      mem.wstrb  <= 4'b0000;
      hit_count  <= 32'h0;
      miss_count <= 32'h0;
      line_valid <= '0;
      flush_pend <= 1'b0;
      fill_pend  <= 1'b0;
      fill_idx   <= '0;
      fill_tag   <= '0;
    end else begin
      cpu.ready <= rd_hit || mem_done;

      if (rd_hit) begin
        cpu.rdata <= line_data[lk_idx];
        hit_count <= hit_count + 32'd1;
      end
      if (rd_miss) miss_count <= miss_count + 32'd1;

      if (accept && !rd_hit) begin
        mem.valid <= 1'b1;
        mem.instr <= cpu.instr;
        mem.addr  <= cpu.addr;
        mem.wdata <= cpu.wdata;
        mem.wstrb <= cpu.wstrb;
        fill_pend <= rd_miss;
        fill_idx  <= lk_idx;
        fill_tag  <= lk_tag;
      end

      // Writes return no data; reads pass memory data straight through.
      if (mem_done) begin
        mem.valid <= 1'b0;
        cpu.rdata <= (mem.wstrb == 4'b0000) ? mem.rdata : 32'h0;
        if (fill_pend) line_valid[fill_idx] <= 1'b1;
      end

      // A flush that arrives with an accepted request, or while busy, waits for the next IDLE edge.
      if (state == IDLE) flush_pend <= flush && accept;
      else               flush_pend <= flush_pend || flush;

      if (clear_lines) line_valid <= '0;
    end
  end

  // Tag and data storage carry no reset; line_valid alone decides whether they mean anything.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (wr_hit) begin
        for (int b = 0; b < 4; b++) begin
          if (cpu.wstrb[b]) line_data[lk_idx][8*b +: 8] <= cpu.wdata[8*b +: 8];
        end
      end
      if (mem_done && fill_pend) begin
        line_tag[fill_idx]  <= fill_tag;
        line_data[fill_idx] <= mem.rdata;
      end
    end
  end

endmodule

// File: tb/tb_picorv32_mem_cache.sv
// Directed bench for picorv32_mem_cache at LINES=16 with a two-cycle-latency memory model.
module tb_picorv32_mem_cache;

  logic        clk;
  logic        reset;
  logic        flush;
  logic [31:0] hit_count;
  logic [31:0] miss_count;
  logic [1:0]  dbg_state;

  picorv32_mem_cache_if cpu_bus ();
  picorv32_mem_cache_if mem_bus ();

  picorv32_mem_cache #(
    .LINES         (16),
    .UNCACHED_BASE (32'h1000_0000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .cpu        (cpu_bus),
    .mem        (mem_bus),
    .hit_count  (hit_count),
    .miss_count (miss_count),
    .dbg_state  (dbg_state)
  );

  int vectors     = 0;
  int miscompares = 0;

  // memory model and transaction log
  logic [31:0] mem_model [logic [31:0]];
  logic        mem_auto  = 1'b1;
  int          txn_count = 0;
  int          wait_cnt  = 0;
  logic [31:0] last_addr;
  logic [31:0] last_wdata;
  logic [3:0]  last_wstrb;

  // results of the most recent cpu_access
  logic [31:0] rd;
  int          rc;
  int          yc;
  int          tx;

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  // memory responder: ready two cycles after valid is first seen
  initial begin
    logic [31:0] tmp;
    mem_bus.ready = 1'b0;
    mem_bus.rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      mem_bus.ready = 1'b0;
      if (mem_auto && mem_bus.valid) begin
        wait_cnt++;
        if (wait_cnt == 2) begin
          wait_cnt   = 0;
          txn_count++;
          last_addr  = mem_bus.addr;
          last_wdata = mem_bus.wdata;
          last_wstrb = mem_bus.wstrb;
          tmp = mem_model.exists(mem_bus.addr) ? mem_model[mem_bus.addr] : 32'h0;
          if (mem_bus.wstrb != 4'b0000) begin
            for (int b = 0; b < 4; b++)
              if (mem_bus.wstrb[b]) tmp[8*b +: 8] = mem_bus.wdata[8*b +: 8];
            mem_model[mem_bus.addr] = tmp;
            mem_bus.rdata = 32'h0;
          end else begin
            mem_bus.rdata = tmp;
          end
          mem_bus.ready = 1'b1;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // driver tasks
  task automatic apply_reset();
    @(posedge clk); #2;
    reset = 1'b1;
    @(posedge clk); #2;
    @(posedge clk); #2;
    reset = 1'b0;
  endtask

  // flush_cyc: cycle (0 = request cycle) during which flush is pulsed; -1 for none
  task automatic cpu_access(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                            input int flush_cyc);
    int c;
    int start_txn;
    @(posedge clk); #2;
    start_txn       = txn_count;
    cpu_bus.valid   = 1'b1;
    cpu_bus.instr   = 1'b0;
    cpu_bus.addr    = addr;
    cpu_bus.wdata   = wdata;
    cpu_bus.wstrb   = wstrb;
    flush           = (flush_cyc == 0);
    c  = 0;
    rc = -1;
    yc = -1;
    rd = 32'hx;
    while (rc < 0 && c < 40) begin
      @(posedge clk); #2;
      c++;
      flush = (c == flush_cyc);
      if (mem_bus.ready && yc < 0) yc = c;
      if (cpu_bus.ready) begin
        rc = c;
        rd = cpu_bus.rdata;
        vectors++;
        if (mem_bus.valid !== 1'b0) begin
          miscompares++;
          $display("FAIL ready_vs_mem_valid @%h: mem_valid=%b with cpu_ready, want 0", addr, mem_bus.valid);
        end
      end
    end
    cpu_bus.valid = 1'b0;
    cpu_bus.wstrb = 4'b0000;
    flush         = 1'b0;
    tx = txn_count - start_txn;
    vectors++;
    if (rc < 0) begin
      miscompares++;
      $display("FAIL timeout @%h: no cpu_ready within %0d cycles", addr, c);
    end else begin
      @(posedge clk); #2;
      if (cpu_bus.ready !== 1'b0) begin
        miscompares++;
        $display("FAIL ready_pulse @%h: cpu_ready=%b one cycle after response, want 0", addr, cpu_bus.ready);
      end
    end
  endtask

  // scenario tasks
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    vectors++;
    if (cpu_bus.ready !== 1'b0) begin miscompares++; $display("FAIL rst_cpu_ready: got %b want 0", cpu_bus.ready); end
    vectors++;
    if (cpu_bus.rdata !== 32'h0) begin miscompares++; $display("FAIL rst_cpu_rdata: got %h want 0", cpu_bus.rdata); end
    vectors++;
    if (mem_bus.valid !== 1'b0 || mem_bus.wstrb !== 4'b0 || mem_bus.addr !== 32'h0 || mem_bus.wdata !== 32'h0)
    begin
      miscompares++;
      $display("FAIL rst_mem_fields: valid=%b wstrb=%b addr=%h wdata=%h want all 0",
               mem_bus.valid, mem_bus.wstrb, mem_bus.addr, mem_bus.wdata);
    end
    vectors++;
    if (hit_count !== 32'h0 || miss_count !== 32'h0) begin
      miscompares++; $display("FAIL rst_counters: hit=%0d miss=%0d want 0/0", hit_count, miss_count);
    end
    vectors++;
    if (dbg_state !== 2'd0) begin miscompares++; $display("FAIL rst_state: got %0d want 0", dbg_state); end
  endtask

  task automatic test_miss_then_hit();
    cpu_access(32'h0001_0000, 32'h0, 4'b0000, -1);
    vectors++;
    if (rd !== 32'h1234_5678) begin miscompares++; $display("FAIL miss_rdata: got %h want 12345678", rd); end
    vectors++;
    if (tx !== 1 || yc < 0 || rc !== yc + 1) begin
      miscompares++; $display("FAIL miss_latency: txns=%0d mem_ready_cyc=%0d resp_cyc=%0d want 1 txn, resp=ready+1", tx, yc, rc);
    end
    vectors++;
    if (miss_count !== 32'd1 || hit_count !== 32'd0) begin
      miscompares++; $display("FAIL miss_counters: hit=%0d miss=%0d want 0/1", hit_count, miss_count);
    end
    cpu_access(32'h0001_0000, 32'h0, 4'b0000, -1);
    vectors++;
    if (rd !== 32'h1234_5678) begin miscompares++; $display("FAIL hit_rdata: got %h want 12345678", rd); end
    vectors++;
    if (tx !== 0 || rc !== 1) begin
      miscompares++; $display("FAIL hit_latency: txns=%0d resp_cyc=%0d want 0 txns, resp_cyc 1", tx, rc);
    end
    vectors++;
    if (hit_count !== 32'd1 || miss_count !== 32'd1) begin
      miscompares++; $display("FAIL hit_counters: hit=%0d miss=%0d want 1/1", hit_count, miss_count);
    end
  endtask

  task automatic test_byte_write();
    cpu_access(32'h0001_0000, 32'h0000_AB00, 4'b0010, -1);
    vectors++;
    if (tx !== 1 || last_addr !== 32'h0001_0000 || last_wdata !== 32'h0000_AB00 || last_wstrb !== 4'b0010) begin
      miscompares++;
      $display("FAIL wr_downstream: txns=%0d addr=%h wdata=%h wstrb=%b want 1 00010000 0000ab00 0010",
               tx, last_addr, last_wdata, last_wstrb);
    end
    vectors++;
    if (rc !== yc + 1) begin miscompares++; $display("FAIL wr_latency: resp_cyc=%0d mem_ready_cyc=%0d want resp=ready+1", rc, yc); end
    vectors++;
    if (hit_count !== 32'd1 || miss_count !== 32'd1) begin
      miscompares++; $display("FAIL wr_counters: hit=%0d miss=%0d want 1/1", hit_count, miss_count);
    end
    cpu_access(32'h0001_0000, 32'h0, 4'b0000, -1);
    vectors++;
    if (rd !== 32'h1234_AB78 || tx !== 0 || rc !== 1) begin
      miscompares++; $display("FAIL wr_merge_hit: rdata=%h txns=%0d resp_cyc=%0d want 1234ab78 0 1", rd, tx, rc);
    end
    vectors++;
    if (hit_count !== 32'd2) begin miscompares++; $display("FAIL wr_merge_hitcnt: got %0d want 2", hit_count); end
  endtask

  task automatic test_uncached();
    int total;
    total = 0;
    cpu_access(32'h1000_0000, 32'h0000_0041, 4'b1111, -1);
    total += tx;
    cpu_access(32'h1000_0000, 32'h0, 4'b0000, -1);
    total += tx;
    vectors++;
    if (rd !== 32'h0000_0041) begin miscompares++; $display("FAIL unc_rdata1: got %h want 00000041", rd); end
    cpu_access(32'h1000_0000, 32'h0, 4'b0000, -1);
    total += tx;
    vectors++;
    if (rd !== 32'h0000_0041 || tx !== 1) begin
      miscompares++; $display("FAIL unc_rdata2: rdata=%h txns=%0d want 00000041 1", rd, tx);
    end
    vectors++;
    if (total !== 3) begin miscompares++; $display("FAIL unc_txns: got %0d want 3", total); end
    vectors++;
    if (hit_count !== 32'd2 || miss_count !== 32'd1) begin
      miscompares++; $display("FAIL unc_counters: hit=%0d miss=%0d want 2/1", hit_count, miss_count);
    end
  endtask

  task automatic test_conflict();
    apply_reset();
    cpu_access(32'h0001_0000, 32'h0, 4'b0000, -1);
    vectors++;
    if (rd !== 32'h1234_AB78 || tx !== 1) begin miscompares++; $display("FAIL conf_a1: rdata=%h txns=%0d want 1234ab78 1", rd, tx); end
    cpu_access(32'h0001_0040, 32'h0, 4'b0000, -1);
    vectors++;
    if (rd !== 32'hCAFE_F00D || tx !== 1) begin miscompares++; $display("FAIL conf_b: rdata=%h txns=%0d want cafef00d 1", rd, tx); end
    cpu_access(32'h0001_0000, 32'h0, 4'b0000, -1);
    vectors++;
    if (rd !== 32'h1234_AB78 || tx !== 1) begin miscompares++; $display("FAIL conf_a2: rdata=%h txns=%0d want 1234ab78 1", rd, tx); end
    vectors++;
    if (miss_count !== 32'd3 || hit_count !== 32'd0) begin
      miscompares++; $display("FAIL conf_counters: hit=%0d miss=%0d want 0/3", hit_count, miss_count);
    end
  endtask

  task automatic test_flush();
    // flush together with a hit: served from old contents, cleared afterwards
    cpu_access(32'h0001_0000, 32'h0, 4'b0000, 0);
    vectors++;
    if (rd !== 32'h1234_AB78 || tx !== 0 || rc !== 1) begin
      miscompares++; $display("FAIL flush_hit: rdata=%h txns=%0d resp_cyc=%0d want 1234ab78 0 1", rd, tx, rc);
    end
    // miss with flush pulsed during MEM_REQ
    cpu_access(32'h0001_0000, 32'h0, 4'b0000, 1);
    vectors++;
    if (rd !== 32'h1234_AB78 || tx !== 1) begin
      miscompares++; $display("FAIL flush_midmiss: rdata=%h txns=%0d want 1234ab78 1", rd, tx);
    end
    cpu_access(32'h0001_0000, 32'h0, 4'b0000, -1);
    vectors++;
    if (tx !== 1 || miss_count !== 32'd5) begin
      miscompares++; $display("FAIL flush_after_fill: txns=%0d miss=%0d want 1 5", tx, miss_count);
    end
    cpu_access(32'h0001_0000, 32'h0, 4'b0000, -1);
    vectors++;
    if (tx !== 0 || hit_count !== 32'd2) begin
      miscompares++; $display("FAIL flush_refill_hit: txns=%0d hit=%0d want 0 2", tx, hit_count);
    end
    // flush alone in IDLE
    @(posedge clk); #2;
    flush = 1'b1;
    @(posedge clk); #2;
    flush = 1'b0;
    cpu_access(32'h0001_0000, 32'h0, 4'b0000, -1);
    vectors++;
    if (tx !== 1 || miss_count !== 32'd6 || rd !== 32'h1234_AB78) begin
      miscompares++; $display("FAIL flush_idle: txns=%0d miss=%0d rdata=%h want 1 6 1234ab78", tx, miss_count, rd);
    end
  endtask

  task automatic test_reset_mid_miss();
    cpu_access(32'h0001_0000, 32'h0, 4'b0000, -1);
    vectors++;
    if (tx !== 0) begin miscompares++; $display("FAIL rmm_precached: txns=%0d want 0", tx); end
    mem_auto = 1'b0;
    @(posedge clk); #2;
    cpu_bus.valid = 1'b1;
    cpu_bus.addr  = 32'h0001_0004;
    cpu_bus.wstrb = 4'b0000;
    @(posedge clk); #2;
    vectors++;
    if (mem_bus.valid !== 1'b1) begin miscompares++; $display("FAIL rmm_req: mem_valid=%b want 1", mem_bus.valid); end
    reset         = 1'b1;
    cpu_bus.valid = 1'b0;
    @(posedge clk); #2;
    reset = 1'b0;
    vectors++;
    if (mem_bus.valid !== 1'b0 || cpu_bus.ready !== 1'b0 || hit_count !== 32'd0 || miss_count !== 32'd0) begin
      miscompares++;
      $display("FAIL rmm_after_reset: mem_valid=%b cpu_ready=%b hit=%0d miss=%0d want 0 0 0 0",
               mem_bus.valid, cpu_bus.ready, hit_count, miss_count);
    end
    mem_bus.rdata = 32'hDEAD_BEEF;
    mem_bus.ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      vectors++;
      if (cpu_bus.ready !== 1'b0 || mem_bus.valid !== 1'b0) begin
        miscompares++;
        $display("FAIL rmm_late_ready c%0d: cpu_ready=%b mem_valid=%b want 0 0", i, cpu_bus.ready, mem_bus.valid);
      end
    end
    mem_auto = 1'b1;
    cpu_access(32'h0001_0000, 32'h0, 4'b0000, -1);
    vectors++;
    if (tx !== 1 || miss_count !== 32'd1 || hit_count !== 32'd0 || rd !== 32'h1234_AB78) begin
      miscompares++;
      $display("FAIL rmm_miss_after: txns=%0d miss=%0d hit=%0d rdata=%h want 1 1 0 1234ab78",
               tx, miss_count, hit_count, rd);
    end
  endtask

  initial begin
    reset         = 1'b1;
    flush         = 1'b0;
    cpu_bus.valid = 1'b0;
    cpu_bus.instr = 1'b0;
    cpu_bus.addr  = 32'h0;
    cpu_bus.wdata = 32'h0;
    cpu_bus.wstrb = 4'b0000;
    mem_model[32'h0001_0000] = 32'h1234_5678;
    mem_model[32'h0001_0040] = 32'hCAFE_F00D;
    mem_model[32'h1000_0000] = 32'h0000_0000;

    test_reset();
    test_miss_then_hit();
    test_byte_write();
    test_uncached();
    test_conflict();
    test_flush();
    test_reset_mid_miss();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/picorv32_mem_cache.md
Name: picorv32_mem_cache

Overview:
- Direct-mapped, write-through, word-line read cache on the picorv32 native memory interface.
- Upstream side (cpu_*) connects to the core's mem_* port. Downstream side (mem_*) drives the slow single-port memory / console model with the same valid/ready protocol.
- Cuts read-hit latency to 1 cycle for dhrystone runs.
- An uncached window bypasses the cache for MMIO such as the console at 0x1000_0000.

Parameters:
- LINES, 256, number of cache lines, one 32-bit word each; power of 2, >= 2.
- UNCACHED_BASE, 32'h1000_0000, addresses >= this bypass the cache.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  single-cycle pulse; invalidate all lines.
- cpu_valid  in  1  core request valid; held until cpu_ready.
- cpu_instr  in  1  instruction fetch flag; forwarded only.
- cpu_addr  in  32  byte address, word aligned.
- cpu_wdata  in  32  write data.
- cpu_wstrb  in  4  byte write strobes; 0 means read.
- cpu_ready  out  1  one-cycle response pulse.
- cpu_rdata  out  32  read data, valid while cpu_ready=1.
- mem_valid  out  1  downstream request.
- mem_instr  out  1  copy of cpu_instr for the current request.
- mem_addr  out  32  copy of cpu_addr.
- mem_wdata  out  32  copy of cpu_wdata.
- mem_wstrb  out  4  copy of cpu_wstrb.
- mem_ready  in  1  downstream response pulse.
- mem_rdata  in  32  downstream read data, valid with mem_ready.
- hit_count  out  32  cached read hits.
- miss_count  out  32  cached read misses.

Behaviour:
- Address split: IDX = log2(LINES). index = cpu_addr[2 +: IDX]; tag = cpu_addr[31:2+IDX]. Each line holds valid, tag and 32-bit data.
- Reset (synchronous, priority over everything):
  - cpu_ready=0, mem_valid=0, mem_wstrb=0, mem_addr/wdata/instr=0, cpu_rdata=0.
  - All valid bits cleared; counters=0; state=IDLE.
  - Reset during MEM_REQ drops mem_valid on the next edge and discards any later mem_ready.
- States: IDLE, MEM_REQ, RESP.
- IDLE accepts a request when cpu_valid=1 and cpu_ready=0. No acceptance in the cycle cpu_ready is high, so each request gets exactly one response.
- Cached read hit (addr < UNCACHED_BASE, wstrb=0, line valid, tag match):
  - At the next edge: cpu_ready=1, cpu_rdata=line data, hit_count+1.
  - Go to RESP. No downstream access.
- Cached read miss:
  - At the next edge: mem_valid=1 with request fields copied; go to MEM_REQ; miss_count+1.
  - On the mem_ready edge: line is filled (valid=1, tag, data=mem_rdata).
  - Next edge: mem_valid=0, cpu_ready=1, cpu_rdata=mem_rdata.
  - Latency is 1 cycle after mem_ready.
- Write, any address (write-through, no write-allocate):
  - Forwarded downstream as for a miss.
  - If the address is cached and hits, the line's bytes are merged per cpu_wstrb at the acceptance edge.
  - Misses leave the cache unchanged. Counters are unchanged.
  - cpu_ready fires 1 cycle after mem_ready; cpu_rdata is don't-care (drive 0).
- Uncached read (addr >= UNCACHED_BASE): always forwarded; no fill, no counter change.
- MEM_REQ: mem_valid and request fields stay stable until mem_ready; a mem_ready pulse leaves MEM_REQ.
- RESP: cpu_ready deasserts at the next edge; return to IDLE.
- cpu_ready is strictly one-cycle.
- mem_valid is never high in the same cycle as cpu_ready.
- flush:
  - In IDLE with no request being accepted: all valid bits clear at that edge.
  - Otherwise it is latched as pending and applied at the first IDLE edge. An in-flight fill completes and its response is still delivered; the filled line is then invalidated.
  - A flush coinciding with a hit in IDLE: the hit is served from the old contents, then the clear is applied.
- Counters wrap 0xFFFF_FFFF -> 0.

Test Plan:
- Miss then hit: LINES=16, memory[0x10000]=0x12345678; read 0x10000 twice.
  - First read: mem_valid next cycle; cpu_rdata=0x12345678 one cycle after mem_ready; miss_count=1.
  - Second read: no mem_valid; cpu_ready 1 cycle after request; hit_count=1.
- Byte write hit: after the above, write 0x10000 wstrb=4'b0010 wdata=0x0000AB00.
  - Downstream write with identical fields.
  - Subsequent read hits and returns 0x1234AB78.
- Uncached path: write 0x1000_0000 wdata=0x41, then read 0x1000_0000 twice -> three downstream transactions; counters unchanged.
- Conflict eviction: read 0x10000, 0x10040, 0x10000 (same index at LINES=16) -> three misses, miss_count=3, zero hits.
- Flush mid-miss: pulse flush while in MEM_REQ for 0x10000 -> response still returns the correct data; the following read of 0x10000 misses.
- Reset mid-miss: assert reset for one cycle while mem_valid=1.
  - Next cycle: mem_valid=0, cpu_ready=0, counters=0.
  - A late mem_ready is ignored; the previously cached 0x10000 now misses.
